ariane_regfile_ff_fwd: RTL and testbench
========================================

Name: ariane_regfile_ff_fwd

Overview:
Flip-flop register file for the CVA6 issue/commit path, generalised to N write ports and M read ports with configurable data width and depth. It adds three behaviours:
- deterministic write-port priority with a conflict flag;
- optional same-cycle write-to-read bypass;
- a sequential clear engine that zeroes the whole array one word per cycle, with a busy/done handshake for pipeline flush and context-wipe.
Drop-in successor to the current FF register file in the issue stage.

Parameters:
DATA_WIDTH, 64, width of each register word
ADDR_WIDTH, 5, address width; NUM_WORDS = 2**ADDR_WIDTH
NR_READ_PORTS, 2, number of combinational read ports (1..4)
NR_WRITE_PORTS, 2, number of commit write ports (1..4)
ZERO_REG_ZERO, 1, 1 = word 0 hard-wired to zero
BYPASS_EN, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
raddr_i  in  NR_READ_PORTS x ADDR_WIDTH  read addresses
rdata_o  out  NR_READ_PORTS x DATA_WIDTH  read data (combinational)
waddr_i  in  NR_WRITE_PORTS x ADDR_WIDTH  write addresses
wdata_i  in  NR_WRITE_PORTS x DATA_WIDTH  write data
we_i  in  NR_WRITE_PORTS  write enables
clr_req_i  in  1  request full-array clear (sampled in IDLE only)
clr_busy_o  out  1  clear engine active; writes are dropped while high
clr_done_o  out  1  one-cycle pulse when clear completes
wr_conflict_o  out  1  registered pulse: two or more ports wrote the same address last cycle

Behaviour:
- Reset is asynchronous on rst_ni low. All mem words = 0, FSM = IDLE, clr_busy_o = 0, clr_done_o = 0, wr_conflict_o = 0, clear pointer = 0.
- Writes:
  - On the rising edge, mem[waddr_i[j]] <= wdata_i[j] for each j with we_i[j]=1.
  - If several ports hit the same address, the highest port index wins.
  - If ZERO_REG_ZERO=1, writes to address 0 are discarded.
- Conflict flag: wr_conflict_o is set the cycle after any two enabled ports share an address, and cleared otherwise. Address 0 is excluded when ZERO_REG_ZERO=1. Writes dropped during CLEAR do not raise it.
- Reads:
  - rdata_o[i] = mem[raddr_i[i]], zero-latency.
  - If ZERO_REG_ZERO=1 and raddr_i[i]=0, the result is 0 regardless of bypass.
- Bypass (BYPASS_EN=1, FSM=IDLE): if any enabled write port targets raddr_i[i] this cycle, rdata_o[i] = wdata of the highest such port index. Otherwise mem is returned.
- Bypass (BYPASS_EN=0): rdata_o returns stored state only; new data is visible the cycle after the write.
- Clear FSM states are IDLE, CLEAR and DONE.
  - IDLE: clr_req_i=1 → CLEAR and ptr <= 0. Writes accepted in the same cycle still commit.
  - CLEAR: mem[ptr] <= 0 and ptr <= ptr+1 each cycle. When ptr = NUM_WORDS-1 → DONE.
    - clr_busy_o=1 for exactly NUM_WORDS cycles.
    - we_i is ignored throughout, and bypass is disabled.
    - Reads return the current (partially cleared) contents.
  - DONE: clr_done_o=1 for one cycle, clr_busy_o=0, and writes are accepted again. → IDLE.
  - clr_req_i is ignored outside IDLE. A request held high continuously restarts a new clear after IDLE.
- Request-to-completion latency: clr_req_i in cycle 0 gives clr_busy_o in cycles 1..NUM_WORDS and clr_done_o in cycle NUM_WORDS+1.
- Reset mid-clear: immediate IDLE with mem=0. No clr_done_o pulse is generated.
- The pointer is ADDR_WIDTH bits wide. Terminal-count detection is explicit and never relies on wrap-around.
- Implementation is pure flip-flops; there is no latch or clock-gate variant.

Test Plan:
- Reset then read all 32 addresses on both ports → all 0; clr_busy_o=0, clr_done_o=0, wr_conflict_o=0.
- Priority and conflict: port0 writes addr 5 = 0x1111, port1 writes addr 5 = 0x2222 in the same cycle → mem[5]=0x2222 next cycle; wr_conflict_o=1 for exactly one cycle. Repeat on addr 0 with ZERO_REG_ZERO=1 → read 0, no conflict.
- Bypass: write addr 7 = 0xDEAD_BEEF and read addr 7 in the same cycle → rdata_o = 0xDEAD_BEEF when BYPASS_EN=1. With BYPASS_EN=0 → old value (0) that cycle, 0xDEAD_BEEF the next.
- Clear:
  - Preload addr 1..31 = index value, pulse clr_req_i at cycle 0.
  - Required: clr_busy_o high for cycles 1..32, clr_done_o high in cycle 33.
  - Reading addr 31 at cycle 16 → 31; at cycle 33 → 0.
  - A write to addr 3 = 0xAA at cycle 10 is dropped (reads 0 after done).
- Reset mid-clear: assert rst_ni low at cycle 12 of CLEAR → all words 0, FSM IDLE, no clr_done_o pulse. A fresh clr_req_i then completes normally in 33 cycles.
- Back-to-back: clr_req_i held high for 80 cycles → two complete clears, each with exactly one clr_done_o pulse, separated by one IDLE cycle.

Source files
------------

// File: rtl/ariane_regfile_ff_fwd.sv
// ============================================================================
// Module   : ariane_regfile_ff_fwd
// Purpose  : Flip-flop register file with N write / M read ports, write-port
//            priority with conflict flag, same-cycle bypass and a clear engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ariane_regfile_ff_fwd #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter bit          ZERO_REG_ZERO  = 1'b1,
    parameter bit          BYPASS_EN      = 1'b1
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]       raddr_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]       rdata_o,
    input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]      waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]      wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]                      we_i,
    input  logic                                           clr_req_i,
    output logic                                           clr_busy_o,
    output logic                                           clr_done_o,
    output logic                                           wr_conflict_o
);

    localparam int unsigned             c_NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]   c_PTR_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [ADDR_WIDTH-1:0]           r_ptr;
    logic [DATA_WIDTH-1:0]           r_mem [c_NUM_WORDS];
    logic                            r_conflict;
    logic                            w_conflict;
    logic                            w_wr_allow;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] w_rdata;

    assign w_wr_allow = (r_state != S_CLEAR);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (clr_req_i) w_state_next = S_CLEAR;
            S_CLEAR: if (r_ptr == c_PTR_LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && clr_req_i) begin
                r_ptr <= '0;
            end else if (r_state == S_CLEAR && r_ptr != c_PTR_LAST) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Ascending port loop: the last matching assignment (highest index) wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < c_NUM_WORDS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else begin
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                if (we_i[j] && !(ZERO_REG_ZERO && waddr_i[j] == '0)) begin
                    r_mem[waddr_i[j]] <= wdata_i[j];
                end
            end
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            for (int k = j + 1; k < NR_WRITE_PORTS; k++) begin
                if (we_i[j] && we_i[k] && waddr_i[j] == waddr_i[k] &&
                    !(ZERO_REG_ZERO && waddr_i[j] == '0)) begin
                    w_conflict = 1'b1;
                end
            end
        end
        w_conflict = w_conflict & w_wr_allow;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_conflict;
        end
    end

    // Forwarding only in IDLE; the hard zero overrides any forwarded value.
    always_comb begin
        for (int i = 0; i < NR_READ_PORTS; i++) begin
            w_rdata[i] = r_mem[raddr_i[i]];
            if (BYPASS_EN && r_state == S_IDLE) begin
                for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                    if (we_i[j] && waddr_i[j] == raddr_i[i]) begin
                        w_rdata[i] = wdata_i[j];
                    end
                end
            end
            if (ZERO_REG_ZERO && raddr_i[i] == '0) begin
                w_rdata[i] = '0;
            end
        end
    end

    assign rdata_o       = w_rdata;
    assign clr_busy_o    = (r_state == S_CLEAR);
    assign clr_done_o    = (r_state == S_DONE);
    assign wr_conflict_o = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_ariane_regfile_ff_fwd.sv
// ============================================================================
// Module   : tb_ariane_regfile_ff_fwd
// Purpose  : Directed self-checking bench for ariane_regfile_ff_fwd.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ariane_regfile_ff_fwd;

    logic             clk_i;
    logic             rst_ni;
    logic [1:0][4:0]  raddr;
    logic [1:0][63:0] rdata;
    logic [1:0][63:0] rdata_nb;
    logic [1:0][4:0]  waddr;
    logic [1:0][63:0] wdata;
    logic [1:0]       we;
    logic             clr_req;
    logic             busy, done, confl;
    logic             busy_nb, done_nb, confl_nb;

    int n_checks = 0;
    int n_fail   = 0;

    ariane_regfile_ff_fwd #(.BYPASS_EN(1'b1)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rdata),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .clr_req_i(clr_req),
        .clr_busy_o(busy), .clr_done_o(done), .wr_conflict_o(confl)
    );

    ariane_regfile_ff_fwd #(.BYPASS_EN(1'b0)) u_nobyp (
        .clk_i(clk_i), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rdata_nb),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .clr_req_i(clr_req),
        .clr_busy_o(busy_nb), .clr_done_o(done_nb), .wr_conflict_o(confl_nb)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        we = '0; waddr = '0; wdata = '0; clr_req = 1'b0;
    endtask

    task automatic write1(input logic [4:0] a, input logic [63:0] d);
        we = 2'b01; waddr[0] = a; wdata[0] = d;
        tick();
        we = '0;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a); raddr[1] = 5'(31 - a);
            #1;
            n_checks++;
            if (rdata[0] !== 64'd0) begin
                n_fail++; $display("FAIL reset_rd0[%0d]: got %h expected 0", a, rdata[0]);
            end
            n_checks++;
            if (rdata[1] !== 64'd0) begin
                n_fail++; $display("FAIL reset_rd1[%0d]: got %h expected 0", 31 - a, rdata[1]);
            end
        end
        n_checks++;
        if ({busy, done, confl} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, confl});
        end
    endtask

    task automatic test_priority();
        we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
        wdata[0] = 64'h1111; wdata[1] = 64'h2222; raddr[0] = 5'd5;
        #1;
        n_checks++;
        if (rdata[0] !== 64'h2222) begin
            n_fail++; $display("FAIL prio_bypass: got %h expected 2222", rdata[0]);
        end
        tick();
        we = '0;
        #1;
        n_checks++;
        if (rdata[0] !== 64'h2222) begin
            n_fail++; $display("FAIL prio_mem: got %h expected 2222", rdata[0]);
        end
        n_checks++;
        if (rdata_nb[0] !== 64'h2222) begin
            n_fail++; $display("FAIL prio_mem_nobyp: got %h expected 2222", rdata_nb[0]);
        end
        n_checks++;
        if (confl !== 1'b1) begin
            n_fail++; $display("FAIL prio_conflict_set: got %b expected 1", confl);
        end
        tick();
        n_checks++;
        if (confl !== 1'b0) begin
            n_fail++; $display("FAIL prio_conflict_clr: got %b expected 0", confl);
        end
        // Same collision on the hard-zero word
        we = 2'b11; waddr[0] = 5'd0; waddr[1] = 5'd0; raddr[0] = 5'd0;
        #1;
        n_checks++;
        if (rdata[0] !== 64'd0) begin
            n_fail++; $display("FAIL zero_bypass: got %h expected 0", rdata[0]);
        end
        tick();
        we = '0;
        #1;
        n_checks++;
        if (rdata[0] !== 64'd0) begin
            n_fail++; $display("FAIL zero_mem: got %h expected 0", rdata[0]);
        end
        n_checks++;
        if (confl !== 1'b0) begin
            n_fail++; $display("FAIL zero_conflict: got %b expected 0", confl);
        end
    endtask

    task automatic test_bypass();
        raddr[0] = 5'd7; raddr[1] = 5'd7;
        we = 2'b01; waddr[0] = 5'd7; wdata[0] = 64'hDEAD_BEEF;
        #1;
        n_checks++;
        if (rdata[0] !== 64'hDEAD_BEEF) begin
            n_fail++; $display("FAIL byp_same_cycle: got %h expected deadbeef", rdata[0]);
        end
        n_checks++;
        if (rdata_nb[0] !== 64'd0) begin
            n_fail++; $display("FAIL nobyp_same_cycle: got %h expected 0", rdata_nb[0]);
        end
        tick();
        we = '0;
        #1;
        n_checks++;
        if (rdata_nb[1] !== 64'hDEAD_BEEF) begin
            n_fail++; $display("FAIL nobyp_next_cycle: got %h expected deadbeef", rdata_nb[1]);
        end
        n_checks++;
        if (rdata[1] !== 64'hDEAD_BEEF) begin
            n_fail++; $display("FAIL byp_next_cycle: got %h expected deadbeef", rdata[1]);
        end
        // Two ports to the same read address: highest index forwarded
        we = 2'b11; waddr[0] = 5'd9; waddr[1] = 5'd9;
        wdata[0] = 64'hAAAA; wdata[1] = 64'hBBBB; raddr[1] = 5'd9;
        #1;
        n_checks++;
        if (rdata[1] !== 64'hBBBB) begin
            n_fail++; $display("FAIL byp_prio: got %h expected bbbb", rdata[1]);
        end
        tick();
        we = '0;
        tick();
    endtask

    task automatic test_clear();
        for (int a = 1; a < 32; a++) write1(5'(a), 64'(a));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 10) begin
                we = 2'b01; waddr[0] = 5'd3; wdata[0] = 64'hAA; raddr[1] = 5'd3;
            end else begin
                we = '0;
            end
            if (c == 16 || c == 33) raddr[0] = 5'd31;
            #1;
            n_checks++;
            if (busy !== (c <= 32)) begin
                n_fail++; $display("FAIL clr_busy c%0d: got %b expected %b", c, busy, (c <= 32));
            end
            n_checks++;
            if (done !== (c == 33)) begin
                n_fail++; $display("FAIL clr_done c%0d: got %b expected %b", c, done, (c == 33));
            end
            if (c == 10) begin
                n_checks++;
                if (rdata[1] !== 64'd0) begin
                    n_fail++; $display("FAIL clr_no_bypass: got %h expected 0", rdata[1]);
                end
            end
            if (c == 16) begin
                n_checks++;
                if (rdata[0] !== 64'd31) begin
                    n_fail++; $display("FAIL clr_rd31_mid: got %h expected 1f", rdata[0]);
                end
            end
            if (c == 33) begin
                n_checks++;
                if (rdata[0] !== 64'd0) begin
                    n_fail++; $display("FAIL clr_rd31_done: got %h expected 0", rdata[0]);
                end
            end
            if (c == 11) begin
                n_checks++;
                if (confl !== 1'b0) begin
                    n_fail++; $display("FAIL clr_conflict: got %b expected 0", confl);
                end
            end
            tick();
        end
        we = '0; raddr[0] = 5'd3; raddr[1] = 5'd17;
        #1;
        n_checks++;
        if (rdata[0] !== 64'd0 || rdata[1] !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL clr_after: got %h %h busy=%b done=%b expected 0 0 0 0",
                               rdata[0], rdata[1], busy, done);
        end
    endtask

    task automatic run_clear_and_measure(input string name);
        int cyc;
        int nbusy;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cyc = 1; nbusy = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) nbusy++;
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != 33 || nbusy != 32) begin
            n_fail++; $display("FAIL %s: done at cycle %0d busy %0d expected 33 32", name, cyc, nbusy);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        write1(5'd4, 64'h44);
        write1(5'd31, 64'h55);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        rst_ni = 1'b0;
        raddr[0] = 5'd4; raddr[1] = 5'd31;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_flags: busy=%b done=%b expected 0 0", busy, done);
        end
        n_checks++;
        if (rdata[0] !== 64'd0 || rdata[1] !== 64'd0) begin
            n_fail++; $display("FAIL rstmid_mem: got %h %h expected 0 0", rdata[0], rdata[1]);
        end
        tick();
        rst_ni = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_quiet c%0d: busy=%b done=%b expected 0 0", c, busy, done);
            end
        end
        run_clear_and_measure("rstmid_fresh_clear");
    endtask

    task automatic test_back_to_back();
        int ndone;
        int pos;
        int guard;
        ndone = 0;
        clr_req = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 80) clr_req = 1'b0;
            pos = c % 34;
            if (done === 1'b1) ndone++;
            n_checks++;
            if (busy !== (pos >= 1 && pos <= 32)) begin
                n_fail++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, busy, (pos >= 1 && pos <= 32));
            end
            n_checks++;
            if (done !== (pos == 33)) begin
                n_fail++; $display("FAIL b2b_done c%0d: got %b expected %b", c, done, (pos == 33));
            end
        end
        n_checks++;
        if (ndone != 2) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", ndone);
        end
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_third_done: timeout, done=%b expected 1", done);
        end
        tick();
    endtask

    initial begin
        rst_ni = 1'b0;
        raddr  = '0;
        idle_inputs();
        repeat (3) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        tick();
        test_reset();
        test_priority();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
